// File: rtl/bus_dest_regfile_if.sv
// rtl/bus_dest_regfile_if.sv - bus-side signal bundle between control/datapath and the destination register file (optional BUS_DEST_WRITE_COUNT_EN adds write_count)
interface bus_dest_regfile_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16
);
  logic [DATA_W-1:0]  BusMuxOut;
  logic [NUM_GPR-1:0] R_in;
  logic               HI_in;
  logic               LO_in;
  logic               BAout;
  logic [DATA_W-1:0]  BusMuxIn_R0;
  logic [DATA_W-1:0]  BusMuxIn_R1;
  logic [DATA_W-1:0]  BusMuxIn_R2;
  logic [DATA_W-1:0]  BusMuxIn_R3;
  logic [DATA_W-1:0]  BusMuxIn_R4;
  logic [DATA_W-1:0]  BusMuxIn_R5;
  logic [DATA_W-1:0]  BusMuxIn_R6;
  logic [DATA_W-1:0]  BusMuxIn_R7;
  logic [DATA_W-1:0]  BusMuxIn_R8;
  logic [DATA_W-1:0]  BusMuxIn_R9;
  logic [DATA_W-1:0]  BusMuxIn_R10;
  logic [DATA_W-1:0]  BusMuxIn_R11;
  logic [DATA_W-1:0]  BusMuxIn_R12;
  logic [DATA_W-1:0]  BusMuxIn_R13;
  logic [DATA_W-1:0]  BusMuxIn_R14;
  logic [DATA_W-1:0]  BusMuxIn_R15;
  logic [DATA_W-1:0]  BusMuxIn_HI;
  logic [DATA_W-1:0]  BusMuxIn_LO;
  logic               load_any;
`ifdef BUS_DEST_WRITE_COUNT_EN
  logic [15:0]        write_count;
`endif

  // Control unit / bus mux side
  modport master (
    output BusMuxOut, R_in, HI_in, LO_in, BAout,
`ifdef BUS_DEST_WRITE_COUNT_EN
    input  write_count,
`endif
    input  BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
    input  BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
    input  BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
    input  BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
    input  BusMuxIn_HI, BusMuxIn_LO, load_any
  );

  // Register file side
  modport slave (
    input  BusMuxOut, R_in, HI_in, LO_in, BAout,
`ifdef BUS_DEST_WRITE_COUNT_EN
    output write_count,
`endif
    output BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
    output BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
    output BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
    output BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
    output BusMuxIn_HI, BusMuxIn_LO, load_any
  );
endinterface

// File: rtl/bus_dest_regfile.sv
// rtl/bus_dest_regfile.sv - R0..R15/HI/LO capture registers at the bus destination with R0 base-address gating (optional BUS_DEST_WRITE_COUNT_EN write counter)
module bus_dest_regfile #(
  parameter int                 DATA_W    = 32,
  parameter int                 NUM_GPR   = 16,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  bus_dest_regfile_if.slave bus
);

  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] gpr_d [NUM_GPR];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              load_any_q, load_any_d;

  // Next-state: every enabled register takes the same bus value, others hold
  always_comb begin
    for (int n = 0; n < NUM_GPR; n++) begin
      gpr_d[n] = gpr_q[n];
      if (bus.R_in[n]) gpr_d[n] = bus.BusMuxOut;
    end
    hi_d       = bus.HI_in ? bus.BusMuxOut : hi_q;
    lo_d       = bus.LO_in ? bus.BusMuxOut : lo_q;
    load_any_d = |{bus.R_in, bus.HI_in, bus.LO_in};
  end

  // Register state; clr overrides any load enable immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int n = 0; n < NUM_GPR; n++) gpr_q[n] <= RESET_VAL;
      hi_q       <= RESET_VAL;
      lo_q       <= RESET_VAL;
      load_any_q <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_GPR; n++) gpr_q[n] <= gpr_d[n];
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      load_any_q <= load_any_d;
    end
  end

  // R0 is masked only on the way out so effective-address math sees a zero base
  assign bus.BusMuxIn_R0  = bus.BAout ? '0 : gpr_q[0];
  assign bus.BusMuxIn_R1  = gpr_q[1];
  assign bus.BusMuxIn_R2  = gpr_q[2];
  assign bus.BusMuxIn_R3  = gpr_q[3];
  assign bus.BusMuxIn_R4  = gpr_q[4];
  assign bus.BusMuxIn_R5  = gpr_q[5];
  assign bus.BusMuxIn_R6  = gpr_q[6];
  assign bus.BusMuxIn_R7  = gpr_q[7];
  assign bus.BusMuxIn_R8  = gpr_q[8];
  assign bus.BusMuxIn_R9  = gpr_q[9];
  assign bus.BusMuxIn_R10 = gpr_q[10];
  assign bus.BusMuxIn_R11 = gpr_q[11];
  assign bus.BusMuxIn_R12 = gpr_q[12];
  assign bus.BusMuxIn_R13 = gpr_q[13];
  assign bus.BusMuxIn_R14 = gpr_q[14];
  assign bus.BusMuxIn_R15 = gpr_q[15];
  assign bus.BusMuxIn_HI  = hi_q;
  assign bus.BusMuxIn_LO  = lo_q;
  assign bus.load_any     = load_any_q;

`ifdef BUS_DEST_WRITE_COUNT_EN
  logic [15:0] wcnt_q, wcnt_d;

  // One count per capturing edge regardless of how many enables; sticks at all-ones
  always_comb begin
    wcnt_d = wcnt_q;
    if (load_any_d && (wcnt_q != 16'hFFFF)) wcnt_d = wcnt_q + 16'd1;
  end

  // Counter register, cleared with the rest of the file
  always_ff @(posedge clk or posedge clr) begin
    if (clr) wcnt_q <= 16'd0;
    else     wcnt_q <= wcnt_d;
  end

  assign bus.write_count = wcnt_q;
`endif

endmodule
